// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with true-LRU replacement and a request/ready memory port.
// Optional build macro CACHE_WRITE_THROUGH_EN: every write also pushes its updated block to memory.
module cache_nway #(
    parameter int ADDR_SIZE  = 10,
    parameter int BLOCK_SIZE = 128,
    parameter int BYTE       = 8,
    parameter int WAYS       = 2,
    parameter int SETS       = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_req,
    input  logic                  in_row,
    input  logic [ADDR_SIZE-1:0]  in_addr,
    input  logic [BYTE-1:0]       in_write_data,
    output logic                  out_ready,
    output logic                  out_done,
    output logic                  hit_or_miss,
    output logic [BYTE-1:0]       out_read_data,
    output logic                  out_mem_req,
    output logic                  out_row,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [BLOCK_SIZE-1:0] out_write_data,
    input  logic                  in_mem_ready,
    input  logic [BLOCK_SIZE-1:0] in_read_data
);

    localparam int NBYTES = BLOCK_SIZE / BYTE;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_SIZE - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAYS-1:0][WAY_W-1:0] age_t;
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_RESPOND} state_t;

    state_t                          r_state;
    logic                            r_ready;
    logic                            r_done;
    logic                            r_hit;
    logic [BYTE-1:0]                 r_rdata;
    logic                            r_mem_req;
    logic                            r_mem_row;
    logic [ADDR_SIZE-1:0]            r_mem_addr;
    logic [BLOCK_SIZE-1:0]           r_mem_wdata;
    logic                            r_row;
    logic [ADDR_SIZE-1:0]            r_addr;
    logic [BYTE-1:0]                 r_wdata;
    logic [WAY_W-1:0]                r_way;
`ifdef CACHE_WRITE_THROUGH_EN
    logic                            r_wt;
`endif
    logic [WAYS-1:0]                 r_valid [SETS];
    logic [WAYS-1:0]                 r_dirty [SETS];
    logic [WAYS-1:0][TAG_W-1:0]      r_tag   [SETS];
    age_t                            r_age   [SETS];
    logic [BLOCK_SIZE-1:0]           r_data  [SETS][WAYS];

    logic [OFF_W-1:0]                w_off;
    logic [IDX_W-1:0]                w_idx;
    logic [TAG_W-1:0]                w_tag;
    logic                            w_hit;
    logic [WAY_W-1:0]                w_hit_way;
    logic                            w_found;
    logic [WAY_W-1:0]                w_victim;
    logic [WAY_W-1:0]                w_acc_way;
    logic [BLOCK_SIZE-1:0]           w_blk;
    logic [BYTE-1:0]                 w_rd_byte;
    logic [BLOCK_SIZE-1:0]           w_wr_blk;
    age_t                            w_new_age;

    // Accessed way drops to age 0; only ways younger than it age by one, so ages stay a permutation.
    function automatic age_t lru_update(input age_t ages, input logic [WAY_W-1:0] way);
        age_t res;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way) begin
                res[w] = '0;
            end else if (ages[w] < ages[way]) begin
                res[w] = ages[w] + WAY_W'(1);
            end else begin
                res[w] = ages[w];
            end
        end
        return res;
    endfunction

    assign w_off          = r_addr[OFF_W-1:0];
    assign w_idx          = r_addr[OFF_W +: IDX_W];
    assign w_tag          = r_addr[ADDR_SIZE-1 -: TAG_W];
    assign out_ready      = r_ready;
    assign out_done       = r_done;
    assign hit_or_miss    = r_hit;
    assign out_read_data  = r_rdata;
    assign out_mem_req    = r_mem_req;
    assign out_row        = r_mem_row;
    assign out_addr       = r_mem_addr;
    assign out_write_data = r_mem_wdata;

    // Tag match over the indexed set; the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end else begin
                w_hit = w_hit;
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest way.
    always_comb begin
        w_found  = 1'b0;
        w_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w_idx][w]) begin
                w_found  = 1'b1;
                w_victim = WAY_W'(w);
            end else begin
                w_found = w_found;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && (r_age[w_idx][w] == WAY_W'(WAYS - 1))) begin
                w_victim = WAY_W'(w);
            end else begin
                w_victim = w_victim;
            end
        end
    end

    // Byte access and LRU update on the hit way (LOOKUP) or the freshly filled way (RESPOND).
    always_comb begin
        w_acc_way = (r_state == S_RESPOND) ? r_way : w_hit_way;
        w_blk     = r_data[w_idx][w_acc_way];
        w_rd_byte = w_blk[w_off*BYTE +: BYTE];
        w_wr_blk  = w_blk;
        w_wr_blk[w_off*BYTE +: BYTE] = r_wdata;
        w_new_age = lru_update(r_age[w_idx], w_acc_way);
    end

    // Controller FSM with registered outputs plus tag/state/data arrays.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_row   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_row       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_way       <= '0;
`ifdef CACHE_WRITE_THROUGH_EN
            r_wt        <= 1'b0;
`endif
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_req && r_ready) begin
                        r_row   <= in_row;
                        r_addr  <= in_addr;
                        r_wdata <= in_write_data;
                        r_state <= S_LOOKUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_age[w_idx] <= w_new_age;
                        r_hit        <= 1'b1;
                        r_rdata      <= r_row ? r_wdata : w_rd_byte;
                        r_way        <= w_hit_way;
                        if (r_row) begin
                            r_data[w_idx][w_hit_way] <= w_wr_blk;
`ifdef CACHE_WRITE_THROUGH_EN
                            r_wt        <= 1'b1;
                            r_mem_req   <= 1'b1;
                            r_mem_row   <= 1'b1;
                            r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_mem_wdata <= w_wr_blk;
                            r_state     <= S_WRITEBACK;
`else
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hit     <= 1'b0;
                        r_way     <= w_victim;
                        r_mem_req <= 1'b1;
                        if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                            r_mem_row   <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
                            r_mem_wdata <= r_data[w_idx][w_victim];
                            r_state     <= S_WRITEBACK;
`ifdef CACHE_WRITE_THROUGH_EN
                            r_wt        <= 1'b0;
`endif
                        end else begin
                            r_mem_row  <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_state    <= S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (r_mem_req && in_mem_ready) begin
                        r_mem_req <= 1'b0;
`ifdef CACHE_WRITE_THROUGH_EN
                        if (r_wt) begin
                            r_wt    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_FILL;
                        end
`else
                        r_state   <= S_FILL;
`endif
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_FILL: begin
                    // After a write-back the request is dropped for one cycle before the fill is issued.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_row  <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                    end else if (in_mem_ready) begin
                        r_mem_req                <= 1'b0;
                        r_data[w_idx][r_way]     <= in_read_data;
                        r_valid[w_idx][r_way]    <= 1'b1;
                        r_dirty[w_idx][r_way]    <= 1'b0;
                        r_tag[w_idx][r_way]      <= w_tag;
                        r_state                  <= S_RESPOND;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_RESPOND: begin
                    r_age[w_idx] <= w_new_age;
                    r_rdata      <= r_row ? r_wdata : w_rd_byte;
                    if (r_row) begin
                        r_data[w_idx][r_way] <= w_wr_blk;
`ifdef CACHE_WRITE_THROUGH_EN
                        r_wt        <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_row   <= 1'b1;
                        r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        r_mem_wdata <= w_wr_blk;
                        r_state     <= S_WRITEBACK;
`else
                        r_dirty[w_idx][r_way] <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway (default build): vector table with a scoreboard queue,
// a byte-array main memory model, plus reset-during-fill and always-ready sequences.
module tb_cache_nway;

    logic         in_clk;
    logic         in_rst;
    logic         in_req;
    logic         in_row;
    logic [9:0]   in_addr;
    logic [7:0]   in_write_data;
    logic         out_ready;
    logic         out_done;
    logic         hit_or_miss;
    logic [7:0]   out_read_data;
    logic         out_mem_req;
    logic         out_row;
    logic [9:0]   out_addr;
    logic [127:0] out_write_data;
    logic         in_mem_ready;
    logic [127:0] in_read_data;

    cache_nway dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_req         (in_req),
        .in_row         (in_row),
        .in_addr        (in_addr),
        .in_write_data  (in_write_data),
        .out_ready      (out_ready),
        .out_done       (out_done),
        .hit_or_miss    (hit_or_miss),
        .out_read_data  (out_read_data),
        .out_mem_req    (out_mem_req),
        .out_row        (out_row),
        .out_addr       (out_addr),
        .out_write_data (out_write_data),
        .in_mem_ready   (in_mem_ready),
        .in_read_data   (in_read_data)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       row;
        logic [9:0] addr;
        logic [7:0] wd;
        logic       hit;
        logic [7:0] rd;
        int         wb_n;
        logic [9:0] wb_a;
        int         fill_n;
        logic [9:0] fill_a;
    } vec_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] rd;
    } exp_t;

    exp_t       sbq[$];
    vec_t       vecs[12];
    logic [7:0] mem [1024];
    int         n_checks;
    int         n_err;
    int         mcnt;
    int         always_rdy;
    int         wb_n, fill_n;
    logic [9:0] wb_a, fill_a;
    int         lat;
    int         dones;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers a pending transfer after 3 cycles, or at once when always_rdy is set.
    task automatic mem_step();
        if (out_mem_req) begin
            mcnt++;
            if (always_rdy != 0 || mcnt == 3) begin
                in_mem_ready = 1'b1;
                for (int b = 0; b < 16; b++) begin
                    in_read_data[b*8 +: 8] = mem[int'(out_addr) + b];
                end
                if (out_row) begin
                    for (int b = 0; b < 16; b++) begin
                        mem[int'(out_addr) + b] = out_write_data[b*8 +: 8];
                    end
                    wb_n++;
                    wb_a = out_addr;
                end else begin
                    fill_n++;
                    fill_a = out_addr;
                end
            end else begin
                in_mem_ready = 1'b0;
            end
        end else begin
            mcnt = 0;
            in_mem_ready = (always_rdy != 0);
        end
    endtask

    task automatic run_req(input vec_t v, input logic busy_pulse, output int latency);
        int  n;
        bit  got;
        exp_t e;
        n = 0;
        while (!out_ready && n < 50) begin
            @(negedge in_clk);
            mem_step();
            n++;
        end
        check("ready_before_req", out_ready, 1'b1);
        wb_n = 0; fill_n = 0; wb_a = '0; fill_a = '0;
        in_req = 1'b1; in_row = v.row; in_addr = v.addr; in_write_data = v.wd;
        sbq.push_back('{hit: v.hit, rd: v.rd});
        got = 1'b0;
        latency = 0;
        while (!got && latency < 60) begin
            @(negedge in_clk);
            latency++;
            if (busy_pulse) begin
                in_req  = ~in_req;
                in_addr = 10'($urandom_range(0, 1023));
            end else begin
                in_req = 1'b0;
            end
            if (out_done) begin
                got    = 1'b1;
                in_req = 1'b0;
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    check("hit_or_miss", hit_or_miss, e.hit);
                    check("read_data", out_read_data, e.rd);
                end
            end
            mem_step();
        end
        if (!got) begin
            check("done_timeout", 1'b0, 1'b1);
            in_req = 1'b0;
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0; mcnt = 0; always_rdy = 0;
        in_rst = 1'b1; in_req = 1'b0; in_row = 1'b0; in_addr = '0; in_write_data = '0;
        in_mem_ready = 1'b0; in_read_data = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
        mem[10'h200] = 8'hAA;

        //          row   addr     wd     hit   rd     wb wb_a     fl fill_a
        vecs[0]  = '{1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 0, 10'h000, 1, 10'h000};
        vecs[1]  = '{1'b1, 10'h000, 8'hFF, 1'b1, 8'hFF, 0, 10'h000, 0, 10'h000};
        vecs[2]  = '{1'b0, 10'h000, 8'h00, 1'b1, 8'hFF, 0, 10'h000, 0, 10'h000};
        vecs[3]  = '{1'b0, 10'h200, 8'h00, 1'b0, 8'hAA, 0, 10'h000, 1, 10'h200};
        vecs[4]  = '{1'b0, 10'h300, 8'h00, 1'b0, 8'h00, 1, 10'h000, 1, 10'h300};
        vecs[5]  = '{1'b0, 10'h200, 8'h00, 1'b1, 8'hAA, 0, 10'h000, 0, 10'h000};
        vecs[6]  = '{1'b0, 10'h000, 8'h00, 1'b0, 8'hFF, 0, 10'h000, 1, 10'h000};
        vecs[7]  = '{1'b1, 10'h015, 8'h5A, 1'b0, 8'h5A, 0, 10'h000, 1, 10'h010};
        vecs[8]  = '{1'b0, 10'h015, 8'h00, 1'b1, 8'h5A, 0, 10'h000, 0, 10'h000};
        vecs[9]  = '{1'b0, 10'h01F, 8'h00, 1'b1, 8'h00, 0, 10'h000, 0, 10'h000};
        vecs[10] = '{1'b1, 10'h3FF, 8'h77, 1'b0, 8'h77, 0, 10'h000, 1, 10'h3F0};
        vecs[11] = '{1'b0, 10'h3FF, 8'h00, 1'b1, 8'h77, 0, 10'h000, 0, 10'h000};

        repeat (2) @(negedge in_clk);
        check("rst_ready", out_ready, 1'b0);
        check("rst_done", out_done, 1'b0);
        check("rst_hit", hit_or_miss, 1'b0);
        check("rst_rdata", out_read_data, 8'h00);
        check("rst_mem_req", out_mem_req, 1'b0);
        check("rst_row", out_row, 1'b0);
        check("rst_addr", out_addr, 10'h000);
        check("rst_wdata", out_write_data, 128'h0);
        in_rst = 1'b0;
        @(negedge in_clk);
        check("ready_after_rst", out_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i], 1'b0, lat);
            check("wb_count", wb_n, vecs[i].wb_n);
            check("fill_count", fill_n, vecs[i].fill_n);
            if (vecs[i].wb_n > 0) check("wb_addr", wb_a, vecs[i].wb_a);
            if (vecs[i].fill_n > 0) check("fill_addr", fill_a, vecs[i].fill_a);
            if (vecs[i].hit) check("hit_latency", lat, 2);
            if (i == 1) check("mem0_after_write", mem[0], 8'h00);
            if (i == 4) check("mem0_after_evict", mem[0], 8'hFF);
        end

        // Reset while the FILL transfer is still waiting for memory.
        while (!out_ready) @(negedge in_clk);
        in_req = 1'b1; in_row = 1'b0; in_addr = 10'h100;
        @(negedge in_clk);
        in_req = 1'b0;
        for (int n = 0; n < 10 && !out_mem_req; n++) @(negedge in_clk);
        check("fill_req_seen", out_mem_req, 1'b1);
        @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        check("rst_mid_mem_req", out_mem_req, 1'b0);
        check("rst_mid_done", out_done, 1'b0);
        check("rst_mid_ready", out_ready, 1'b0);
        in_rst = 1'b0;
        mcnt = 0;
        @(negedge in_clk);
        check("rst_mid_idle", out_ready, 1'b1);
        run_req('{1'b0, 10'h200, 8'h00, 1'b0, 8'hAA, 0, 10'h000, 1, 10'h200}, 1'b0, lat);
        check("post_rst_fill", fill_n, 1);
        check("post_rst_fill_addr", fill_a, 10'h200);

        // Memory always ready; in_req toggles while the cache is busy.
        always_rdy = 1;
        in_mem_ready = 1'b1;
        run_req('{1'b0, 10'h100, 8'h00, 1'b0, 8'h00, 0, 10'h000, 1, 10'h100}, 1'b1, lat);
        check("rdy_fill_count", fill_n, 1);
        check("rdy_wb_count", wb_n, 0);
        check("rdy_fill_addr", fill_a, 10'h100);
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge in_clk);
            mem_step();
            if (out_done) dones++;
        end
        check("no_extra_done", dones, 0);
        check("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
